// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared state encoding and sweep helpers for the truth-table sweeper
package tt_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Highest vector index of an n-input truth table.
    function automatic int last_vec(input int n);
        return (1 << n) - 1;
    endfunction

endpackage

// File: rtl/tt_vec_counter.sv
// rtl/tt_vec_counter.sv - vector counter with clear, enable and terminal-count flag
module tt_vec_counter
    import tt_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == W'(last_vec(W)));

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps every input vector into two implementations and compares them
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_a,
    input  logic            dut_b,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mism_cnt,
    output logic            first_valid,
    output logic [N_IN-1:0] first_bad
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [1:0]      state_q, state_d;
    logic [SW-1:0]   scnt_q, scnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            fv_q, fv_d;
    logic [N_IN:0]   mism_q, mism_d;
    logic [N_IN-1:0] fb_q, fb_d;
    logic            vec_clr, vec_en, vec_tc;
    logic [N_IN-1:0] vec;
    logic            mismatch;

    // Case inequality so an unknown output from either implementation is a mismatch.
    assign mismatch = (dut_a !== dut_b);

    tt_vec_counter #(.W(N_IN)) u_vec (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (vec_clr),
        .en_i  (vec_en),
        .cnt_o (vec),
        .tc_o  (vec_tc)
    );

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        fv_d    = fv_q;
        mism_d  = mism_q;
        fb_d    = fb_q;
        vec_clr = 1'b0;
        vec_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    scnt_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    fv_d    = 1'b0;
                    mism_d  = '0;
                    fb_d    = '0;
                    vec_clr = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (scnt_q == SW'(SETTLE - 1)) begin
                    state_d = ST_SAMPLE;
                    scnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    mism_d = mism_q + (N_IN + 1)'(1);
                    if (!fv_q) begin
                        fb_d = vec;
                        fv_d = 1'b1;
                    end
                end
                // The last vector is held through DONE rather than wrapping.
                if (vec_tc) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SETTLE;
                    vec_en  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            scnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fv_q    <= 1'b0;
            mism_q  <= '0;
            fb_q    <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fv_q    <= fv_d;
            mism_q  <= mism_d;
            fb_q    <= fb_d;
        end
    end

    assign vec_out     = vec;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = done_q && (mism_q == '0);
    assign mism_cnt    = mism_q;
    assign first_valid = fv_q;
    assign first_bad   = fb_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

    localparam int N1 = 2;
    localparam int S1 = 1;
    localparam int N2 = 3;
    localparam int S2 = 3;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       pass;
        logic       fv;
        logic [3:0] mism;
        logic [2:0] vec;
        logic [2:0] fb;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    logic          start1 = 1'b0;
    logic [N1-1:0] vec1;
    logic          a1, b1, busy1, done1, pass1, fv1;
    logic [N1:0]   mism1;
    logic [N1-1:0] fb1;
    logic [3:0]    flip1 = 4'h0;

    logic          start2 = 1'b0;
    logic [N2-1:0] vec2;
    logic          a2, b2, busy2, done2, pass2, fv2;
    logic [N2:0]   mism2;
    logic [N2-1:0] fb2;
    logic [7:0]    flip2 = 8'h00;

    // Implementation A is a|~b (a = vec[1]); B differs wherever the flip mask is set.
    assign a1 = vec1[1] | ~vec1[0];
    assign b1 = a1 ^ flip1[vec1];
    assign a2 = ^vec2;
    assign b2 = a2 ^ flip2[vec2];

    truth_table_sweeper #(.N_IN(N1), .SETTLE(S1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .vec_out(vec1),
        .dut_a(a1), .dut_b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .mism_cnt(mism1), .first_valid(fv1), .first_bad(fb1)
    );

    truth_table_sweeper #(.N_IN(N2), .SETTLE(S2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .vec_out(vec2),
        .dut_a(a2), .dut_b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .mism_cnt(mism2), .first_valid(fv2), .first_bad(fb2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Outputs as a function of cycles elapsed since the accepted start edge.
    function automatic exp_t model(input int n, input int s, input bit act,
                                   input int t, input logic [7:0] flip);
        exp_t e;
        int nv, q, ns;
        e = '0;
        if (!act) return e;
        nv = 1 << n;
        q  = t / (s + 1);
        ns = (q < nv) ? q : nv;
        e.vec  = 3'((q < nv) ? q : nv - 1);
        e.busy = (t < nv * (s + 1));
        e.done = !e.busy;
        for (int v = 0; v < ns; v++) begin
            if (flip[v]) begin
                if (!e.fv) begin
                    e.fv = 1'b1;
                    e.fb = 3'(v);
                end
                e.mism = e.mism + 4'd1;
            end
        end
        e.pass = e.done && (e.mism == 4'd0);
        return e;
    endfunction

    bit         act1 = 0, act2 = 0;
    int         t1 = 0, t2 = 0;
    logic [7:0] mf1 = 8'h00, mf2 = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act1 = 0; t1 = 0;
            act2 = 0; t2 = 0;
        end else begin
            if (start1 && (!act1 || t1 >= (1 << N1) * (S1 + 1))) begin
                act1 = 1; t1 = 0; mf1 = {4'h0, flip1};
            end else if (act1) begin
                t1++;
            end
            if (start2 && (!act2 || t2 >= (1 << N2) * (S2 + 1))) begin
                act2 = 1; t2 = 0; mf2 = flip2;
            end else if (act2) begin
                t2++;
            end
        end
    end

    always @(negedge clk) begin : cmp
        exp_t e;
        e = model(N1, S1, act1, t1, mf1);
        chk("d1_vec",   vec1,  e.vec);
        chk("d1_busy",  busy1, e.busy);
        chk("d1_done",  done1, e.done);
        chk("d1_pass",  pass1, e.pass);
        chk("d1_mism",  mism1, e.mism);
        chk("d1_fv",    fv1,   e.fv);
        chk("d1_fb",    fb1,   e.fb);
        e = model(N2, S2, act2, t2, mf2);
        chk("d2_vec",   vec2,  e.vec);
        chk("d2_busy",  busy2, e.busy);
        chk("d2_done",  done2, e.done);
        chk("d2_pass",  pass2, e.pass);
        chk("d2_mism",  mism2, e.mism);
        chk("d2_fv",    fv2,   e.fv);
        chk("d2_fb",    fb2,   e.fb);
    end

    task automatic sweep1(input int repulse, output int cyc);
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
            start1 = (cyc == repulse);
        end
        start1 = 1'b0;
        chk("sweep1_reached_done", done1, 1);
    endtask

    task automatic sweep2(output int cyc);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("sweep2_reached_done", done2, 1);
    endtask

    initial begin
        int cyc;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_vec",  vec1,  0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Matching implementations
        sweep1(-1, cyc);
        chk("s1_cycles", cyc, 8);
        chk("s1_pass", pass1, 1);
        chk("s1_mism", mism1, 0);
        chk("s1_fv",   fv1,   0);
        chk("s1_vec",  vec1,  3);

        // Single mismatch at vector 2
        flip1 = 4'b0100;
        sweep1(-1, cyc);
        chk("s2_mism", mism1, 1);
        chk("s2_fb",   fb1,   2);
        chk("s2_fv",   fv1,   1);
        chk("s2_pass", pass1, 0);

        // Every vector mismatches: count reaches 2**N_IN without wrapping
        flip1 = 4'hF;
        sweep1(-1, cyc);
        chk("s3_mism", mism1, 4);
        chk("s3_fb",   fb1,   0);
        chk("s3_pass", pass1, 0);

        // Start during a sweep is ignored
        flip1 = 4'h0;
        sweep1(3, cyc);
        chk("s4_cycles", cyc, 8);
        chk("s4_pass", pass1, 1);

        // Held start re-triggers from DONE
        flip1 = 4'b0010;
        @(negedge clk);
        start1 = 1'b1;
        repeat (25) @(negedge clk);
        start1 = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_done", done1, 1);
        chk("held_mism", mism1, 1);
        chk("held_fb",   fb1,   1);

        // Reset mid-sweep clears everything immediately
        flip1 = 4'h0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("s5_busy", busy1, 0);
        chk("s5_vec",  vec1,  0);
        chk("s5_done", done1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep1(-1, cyc);
        chk("s5_cycles", cyc, 8);
        chk("s5_pass", pass1, 1);

        // Wider table, longer settle
        sweep2(cyc);
        chk("s6_cycles", cyc, 32);
        chk("s6_vec",  vec2,  7);
        chk("s6_pass", pass2, 1);
        repeat (3) @(negedge clk);
        chk("s6_vec_hold", vec2, 7);

        flip2 = 8'b1010_0000;
        sweep2(cyc);
        chk("s6b_mism", mism2, 2);
        chk("s6b_fb",   fb2,   5);
        chk("s6b_pass", pass2, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
